// File: rtl/warp_regfile.sv
// SIMT register file: WARPS x REGS x LANES x WIDTH, two registered read ports, one lane-masked write port, warp-clear engine.
// Latency: reads 1 cycle (registered rdata); writes visible to reads sampled on the following edge (same edge with RF_BYPASS_EN).
// Backpressure: wready drops for the REGS cycles of a warp clear; writes offered then are dropped and must be held upstream.
`timescale 1ns/1ps

module warp_regfile #(
  parameter  int LANES = 16,
  parameter  int WARPS = 8,
  parameter  int REGS  = 32,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(REGS),
  localparam int WW    = (WARPS > 1) ? $clog2(WARPS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LANES-1:0]       write_en,
  input  logic [WW-1:0]          wwarp,
  input  logic [AW-1:0]          waddr,
  input  logic [LANES*WIDTH-1:0] wdata,
  output logic                   wready,
  input  logic [LANES-1:0]       read_en_0,
  input  logic [LANES-1:0]       read_en_1,
  input  logic [WW-1:0]          rwarp_0,
  input  logic [WW-1:0]          rwarp_1,
  input  logic [AW-1:0]          raddr_0,
  input  logic [AW-1:0]          raddr_1,
  output logic [LANES*WIDTH-1:0] rdata_0,
  output logic [LANES*WIDTH-1:0] rdata_1,
  input  logic                   clr_req,
  input  logic [WW-1:0]          clr_warp,
  output logic                   clr_busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                 state, state_nxt;
  logic [AW-1:0]          cnt;
  logic [WW-1:0]          clr_warp_q;

  // Storage is deliberately unreset; contents are undefined until written or cleared.
  logic [WIDTH-1:0]       mem [WARPS][REGS][LANES];

  // Read ports folded into arrays so both share one piece of logic.
  logic [LANES-1:0]       rd_en   [2];
  logic [WW-1:0]          rd_warp [2];
  logic [AW-1:0]          rd_addr [2];
  logic [LANES*WIDTH-1:0] rd_q    [2];
  logic [LANES*WIDTH-1:0] rd_nxt  [2];

  logic                   wr_addr_ok, wr_warp_ok, wr_fire;
  logic [1:0]             rd_addr_ok, rd_warp_ok;

  assign rd_en[0]   = read_en_0;
  assign rd_en[1]   = read_en_1;
  assign rd_warp[0] = rwarp_0;
  assign rd_warp[1] = rwarp_1;
  assign rd_addr[0] = raddr_0;
  assign rd_addr[1] = raddr_1;
  assign rdata_0    = rd_q[0];
  assign rdata_1    = rd_q[1];

  assign clr_busy = (state == CLEAR);
  assign wready   = !clr_busy;

  // Range checks only exist when the index space is not fully populated.
  if (REGS == (1 << AW)) begin : g_reg_full
    assign wr_addr_ok = 1'b1;
    assign rd_addr_ok = 2'b11;
  end else begin : g_reg_part
    assign wr_addr_ok = (waddr < AW'(REGS));
    assign rd_addr_ok = {(raddr_1 < AW'(REGS)), (raddr_0 < AW'(REGS))};
  end

  if (WARPS == (1 << WW)) begin : g_warp_full
    assign wr_warp_ok = 1'b1;
    assign rd_warp_ok = 2'b11;
  end else begin : g_warp_part
    assign wr_warp_ok = (wwarp < WW'(WARPS));
    assign rd_warp_ok = {(rwarp_1 < WW'(WARPS)), (rwarp_0 < WW'(WARPS))};
  end

  assign wr_fire = wready && wr_addr_ok && wr_warp_ok;

  // Clear FSM state register; reset aborts a clear in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Clear FSM next state: one register per cycle, leave after the last one.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_req) state_nxt = CLEAR;
      CLEAR:   if (cnt == AW'(REGS - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Clear counter and latched target warp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      clr_warp_q <= '0;
    end else if (state == IDLE && clr_req) begin
      cnt        <= '0;
      clr_warp_q <= clr_warp;
    end else if (state == CLEAR) begin
      cnt        <= (cnt == AW'(REGS - 1)) ? '0 : cnt + 1'b1;
    end
  end

  // Storage update: clear engine owns the array while busy, otherwise lane-masked writes.
  always_ff @(posedge clk) begin
    if (clr_busy) begin
      for (int l = 0; l < LANES; l++) mem[clr_warp_q][cnt][l] <= '0;
    end else if (wr_fire) begin
      for (int l = 0; l < LANES; l++)
        if (write_en[l]) mem[wwarp][waddr][l] <= wdata[l*WIDTH +: WIDTH];
    end
  end

  // Per-lane read data selection; disabled lanes hold, out-of-range reads give zero.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_nxt[p] = rd_q[p];
      for (int l = 0; l < LANES; l++) begin
        if (rd_en[p][l]) begin
          if (rd_addr_ok[p] && rd_warp_ok[p])
            rd_nxt[p][l*WIDTH +: WIDTH] = mem[rd_warp[p]][rd_addr[p]][l];
          else
            rd_nxt[p][l*WIDTH +: WIDTH] = '0;
`ifdef RF_BYPASS_EN
          // Forward whatever lands in the addressed entry on this same edge.
          if (clr_busy && rd_warp[p] == clr_warp_q && rd_addr[p] == cnt)
            rd_nxt[p][l*WIDTH +: WIDTH] = '0;
          else if (wr_fire && write_en[l] && rd_warp[p] == wwarp && rd_addr[p] == waddr)
            rd_nxt[p][l*WIDTH +: WIDTH] = wdata[l*WIDTH +: WIDTH];
`endif
        end
      end
    end
  end

  // Registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) rd_q[p] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) rd_q[p] <= rd_nxt[p];
    end
  end

endmodule

// File: tb/tb_warp_regfile.sv
`timescale 1ns/1ps

module tb_warp_regfile;
  localparam int LANES = 16;
  localparam int WARPS = 8;
  localparam int REGS  = 32;
  localparam int WIDTH = 32;
  localparam int AW    = 5;
  localparam int WW    = 3;

  logic                   clk;
  logic                   rst_n;
  logic [LANES-1:0]       write_en;
  logic [WW-1:0]          wwarp;
  logic [AW-1:0]          waddr;
  logic [LANES*WIDTH-1:0] wdata;
  logic                   wready;
  logic [LANES-1:0]       read_en_0, read_en_1;
  logic [WW-1:0]          rwarp_0, rwarp_1;
  logic [AW-1:0]          raddr_0, raddr_1;
  logic [LANES*WIDTH-1:0] rdata_0, rdata_1;
  logic                   clr_req;
  logic [WW-1:0]          clr_warp;
  logic                   clr_busy;

  int checks   = 0;
  int failures = 0;

  warp_regfile #(.LANES(LANES), .WARPS(WARPS), .REGS(REGS), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .write_en(write_en), .wwarp(wwarp), .waddr(waddr), .wdata(wdata), .wready(wready),
    .read_en_0(read_en_0), .read_en_1(read_en_1),
    .rwarp_0(rwarp_0), .rwarp_1(rwarp_1),
    .raddr_0(raddr_0), .raddr_1(raddr_1),
    .rdata_0(rdata_0), .rdata_1(rdata_1),
    .clr_req(clr_req), .clr_warp(clr_warp), .clr_busy(clr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] lane(input logic [LANES*WIDTH-1:0] bus, input int l);
    return bus[l*WIDTH +: WIDTH];
  endfunction

  function automatic logic [31:0] pat(input int w, input int r, input int l);
    return {8'(w), 8'(r), 16'(l)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_all(input logic [31:0] v);
    for (int l = 0; l < LANES; l++) wdata[l*WIDTH +: WIDTH] = v;
  endtask

  task automatic fill_pat(input int w, input int r);
    for (int l = 0; l < LANES; l++) wdata[l*WIDTH +: WIDTH] = pat(w, r, l);
  endtask

  initial begin
    rst_n = 1'b0; write_en = '0; wwarp = '0; waddr = '0; wdata = '0;
    read_en_0 = '0; read_en_1 = '0; rwarp_0 = '0; rwarp_1 = '0;
    raddr_0 = '0; raddr_1 = '0; clr_req = 1'b0; clr_warp = '0;

    // Reset state
    #12;
    for (int l = 0; l < LANES; l++) begin
      chk("rst_rdata_0", lane(rdata_0, l), 32'h0);
      chk("rst_rdata_1", lane(rdata_1, l), 32'h0);
    end
    chk("rst_clr_busy", 32'(clr_busy), 32'd0);
    chk("rst_wready", 32'(wready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    step;

    // Basic write/read, both ports on the same entry
    wwarp = 3'd3; waddr = 5'd5; write_en = 16'hFFFF;
    for (int l = 0; l < LANES; l++) wdata[l*WIDTH +: WIDTH] = 32'hA000_0000 + 32'(l);
    step;
    write_en = '0;
    rwarp_0 = 3'd3; raddr_0 = 5'd5; read_en_0 = 16'hFFFF;
    rwarp_1 = 3'd3; raddr_1 = 5'd5; read_en_1 = 16'hFFFF;
    step;
    read_en_0 = '0; read_en_1 = '0;
    for (int l = 0; l < LANES; l++) begin
      chk("basic_p0", lane(rdata_0, l), 32'hA000_0000 + 32'(l));
      chk("basic_p1", lane(rdata_1, l), 32'hA000_0000 + 32'(l));
    end

    // Masked write; port 1 reads with a partial lane enable so other lanes hold
    wwarp = 3'd0; waddr = 5'd1; write_en = 16'hFFFF; fill_all(32'h1111_1111);
    step;
    write_en = 16'h00F0; fill_all(32'h2222_2222);
    step;
    write_en = '0;
    rwarp_0 = 3'd0; raddr_0 = 5'd1; read_en_0 = 16'hFFFF;
    rwarp_1 = 3'd0; raddr_1 = 5'd1; read_en_1 = 16'h000F;
    step;
    read_en_0 = '0; read_en_1 = '0;
    for (int l = 0; l < LANES; l++) begin
      chk("mask_p0", lane(rdata_0, l), (l >= 4 && l <= 7) ? 32'h2222_2222 : 32'h1111_1111);
      chk("hold_p1", lane(rdata_1, l), (l < 4) ? 32'h1111_1111 : 32'hA000_0000 + 32'(l));
    end

    // Warp isolation: fill everything, read back on both ports at different entries
    write_en = 16'hFFFF;
    for (int w = 0; w < WARPS; w++)
      for (int r = 0; r < REGS; r++) begin
        wwarp = 3'(w); waddr = 5'(r); fill_pat(w, r);
        step;
      end
    write_en = '0;
    read_en_0 = 16'hFFFF; read_en_1 = 16'hFFFF;
    for (int w = 0; w < WARPS; w++)
      for (int r = 0; r < REGS; r++) begin
        rwarp_0 = 3'(w);     raddr_0 = 5'(r);
        rwarp_1 = 3'(7 - w); raddr_1 = 5'(31 - r);
        step;
        for (int l = 0; l < LANES; l++) begin
          chk("iso_p0", lane(rdata_0, l), pat(w, r, l));
          chk("iso_p1", lane(rdata_1, l), pat(7 - w, 31 - r, l));
        end
      end
    read_en_0 = '0; read_en_1 = '0;

    // Clear warp 2: busy exactly REGS cycles, writes dropped meanwhile
    clr_req = 1'b1; clr_warp = 3'd2;
    step;
    clr_req = 1'b0; clr_warp = '0;
    wwarp = 3'd1; waddr = 5'd0; write_en = 16'hFFFF; fill_all(32'hFFFF_FFFF);
    for (int i = 0; i < REGS; i++) begin
      chk("clr_busy_hi", 32'(clr_busy), 32'd1);
      chk("clr_wready_lo", 32'(wready), 32'd0);
      step;
    end
    write_en = '0;
    chk("clr_busy_end", 32'(clr_busy), 32'd0);
    chk("clr_wready_end", 32'(wready), 32'd1);
    read_en_0 = 16'hFFFF; read_en_1 = 16'hFFFF;
    for (int r = 0; r < REGS; r++) begin
      rwarp_0 = 3'd2; raddr_0 = 5'(r);
      rwarp_1 = 3'd1; raddr_1 = 5'(r);
      step;
      for (int l = 0; l < LANES; l++) begin
        chk("clr_zero_w2", lane(rdata_0, l), 32'h0);
        chk("clr_keep_w1", lane(rdata_1, l), pat(1, r, l));
      end
    end
    read_en_0 = '0; read_en_1 = '0;

    // Reset 10 cycles into a clear of warp 2
    write_en = 16'hFFFF;
    for (int r = 0; r < REGS; r++) begin
      wwarp = 3'd2; waddr = 5'(r); fill_pat(2, r);
      step;
    end
    write_en = '0;
    clr_req = 1'b1; clr_warp = 3'd2;
    step;
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) step;
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", 32'(clr_busy), 32'd0);
    chk("rstmid_wready", 32'(wready), 32'd1);
    for (int l = 0; l < LANES; l++) begin
      chk("rstmid_rdata_0", lane(rdata_0, l), 32'h0);
      chk("rstmid_rdata_1", lane(rdata_1, l), 32'h0);
    end
    @(negedge clk) rst_n = 1'b1;
    step;
    chk("rstmid_busy_after", 32'(clr_busy), 32'd0);
    read_en_0 = 16'hFFFF; read_en_1 = 16'hFFFF;
    for (int r = 0; r < REGS; r++) begin
      rwarp_0 = 3'd2; raddr_0 = 5'(r);
      rwarp_1 = 3'd2; raddr_1 = 5'(r);
      step;
      for (int l = 0; l < LANES; l++) begin
        chk("rstmid_p0", lane(rdata_0, l), (r < 10) ? 32'h0 : pat(2, r, l));
        chk("rstmid_p1", lane(rdata_1, l), (r < 10) ? 32'h0 : pat(2, r, l));
      end
    end
    read_en_0 = '0; read_en_1 = '0;

    // Same-edge read/write of (0,7)
    wwarp = 3'd0; waddr = 5'd7; write_en = 16'hFFFF; fill_all(32'h1234_5678);
    step;
    fill_all(32'hDEAD_BEEF);
    rwarp_0 = 3'd0; raddr_0 = 5'd7; read_en_0 = 16'hFFFF;
    step;
    write_en = '0;
    for (int l = 0; l < LANES; l++) begin
`ifdef RF_BYPASS_EN
      chk("same_edge", lane(rdata_0, l), 32'hDEAD_BEEF);
`else
      chk("same_edge", lane(rdata_0, l), 32'h1234_5678);
`endif
    end
    step;
    read_en_0 = '0;
    for (int l = 0; l < LANES; l++) chk("after_edge", lane(rdata_0, l), 32'hDEAD_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/warp_regfile.md
# warp_regfile

Parametrised multi-warp, multi-lane SIMT register file with two registered read ports and one lane-masked write port. It sits between the operand-collect and writeback stages of the core. It generalises the fixed 16-lane / 32-register / 8-warp register block in three ways: independent read and write warp selection, lane-masked writes, and a hardware warp-clear engine.

## Interface
- `LANES`, 16, number of SIMT lanes.
- `WARPS`, 8, number of warp contexts.
- `REGS`, 32, registers per lane per warp.
- `WIDTH`, 32, data bits per register.
- Derived: `AW = $clog2(REGS)`, `WW = max(1, $clog2(WARPS))`.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `write_en`  in  LANES  per-lane write mask.
- `wwarp`  in  WW  write warp id.
- `waddr`  in  AW  write register address.
- `wdata`  in  LANES*WIDTH  write data; lane l occupies bits `[l*WIDTH +: WIDTH]`.
- `wready`  out  1  write accepted this cycle. Equals `!clr_busy`.
- `read_en_0`, `read_en_1`  in  LANES each  per-lane read enable, one per port.
- `rwarp_0`, `rwarp_1`  in  WW each  read warp id, one per port.
- `raddr_0`, `raddr_1`  in  AW each  read register address, one per port.
- `rdata_0`, `rdata_1`  out  LANES*WIDTH each  registered read data, lane-packed like `wdata`.
- `clr_req`  in  1  single-cycle pulse requesting a zero-clear of warp `clr_warp`.
- `clr_warp`  in  WW  warp to clear; sampled together with `clr_req`.
- `clr_busy`  out  1  clear engine active.

## Operation
- **Storage.** Array of WARPS x REGS x LANES x WIDTH. It is not reset and its contents are undefined until written or cleared.
- **Write.** On a rising edge with `wready=1`, each lane l with `write_en[l]=1` stores its `wdata` slice at (`wwarp`, `waddr`). Lanes with a 0 mask bit are untouched. Writes presented while `wready=0` are dropped; the upstream stage must hold them until `wready` returns.
- **Read.** Each port is independent. For each lane with `read_en_p[l]=1`, the `rdata_p` lane slice register loads the entry at (`rwarp_p`, `raddr_p`). Lanes with the enable low hold their previous value.
- **Out-of-range addresses.** If `waddr >= REGS`, the write is ignored. If `raddr_p >= REGS`, the read returns 0. This only applies when REGS is not a power of two; the same rule covers warp ids `>= WARPS`.
- **Clear FSM states.** IDLE and CLEAR.
- **IDLE -> CLEAR.** Taken on `clr_req=1`. The engine latches `clr_warp` and sets counter `cnt=0`.
- **CLEAR.** Each cycle the engine writes 0 to all lanes at (latched warp, `cnt`) and increments `cnt`. When `cnt == REGS-1` it performs the final write and returns to IDLE.
- **During CLEAR.** `clr_req` is ignored. Reads are serviced normally.

## Timing
- **Read latency.** 1 cycle. Address and enable sampled at edge N appear on `rdata_p` after edge N.
- **Write visibility.** Data written at edge N is readable by a read sampled at edge N+1 or later. Same-edge behaviour is set by `RF_BYPASS_EN`.
- **Clear duration.** `clr_busy` rises the cycle after the `clr_req` edge and stays high for exactly REGS cycles. `wready` is low for the same window.
- **Clear/write collision.** A `clr_req` and a write on the same IDLE cycle: the write commits, then the clear begins next cycle. If both target the same warp, the clear overwrites the write.
- **Port collision.** Both read ports may address the same entry in the same cycle; both return identical data.
- **Reset values.** `rdata_0=0`, `rdata_1=0`, `clr_busy=0`, `wready=1`, FSM in IDLE, `cnt=0`.
- **Reset mid-clear.** The FSM aborts immediately to IDLE. Registers already zeroed stay zero; the rest keep their old contents.

## Configuration
- **`RF_BYPASS_EN` defined.** Write-to-read forwarding is enabled. If a port reads (warp, addr) on the same edge that lane l is written there, that lane returns the new data. This covers both external writes and clear-engine zero writes.
- **`RF_BYPASS_EN` undefined.** No forwarding. A same-edge read returns the pre-write contents.

## Test plan
- **Basic write/read.** Defaults: write `wwarp=3`, `waddr=5`, `write_en=16'hFFFF`, lane l data `32'hA000_0000+l`; next cycle read both ports at (3,5) with all enables -> every lane on both ports returns `A000_0000+l` one cycle later.
- **Masked write.** Write 0x11111111 to all lanes, then 0x22222222 with `write_en=16'h00F0` -> lanes 4-7 read 0x22222222, all other lanes 0x11111111.
- **Warp isolation.** Fill every warp/register/lane with `{warp, reg, lane}`-encoded data and read all back through both ports -> no cross-warp aliasing.
- **Clear.** Pulse `clr_req`, `clr_warp=2` -> `clr_busy` high for exactly 32 cycles and writes during that window are dropped; warp 2 then reads all zero while warp 1 is unchanged.
- **Reset mid-clear.** Assert `rst_n=0` 10 cycles into a clear -> `clr_busy=0` and `rdata=0` immediately; after reset, regs 0-9 of the cleared warp read 0 and regs 10-31 keep their old data.
- **Same-edge read/write.** Read (0,7) on the same edge as a write of 0xDEADBEEF to (0,7) -> returns 0xDEADBEEF with `RF_BYPASS_EN` defined, the old value without it.
